// File: rtl/tusca_dht11_pkg.sv
// Shared types and constants for the DHT11 measurement front end.
package tusca_dht11_pkg;

    // Measurement FSM; encodings are visible on db_estado.
    typedef enum logic [2:0] {
        Ocioso      = 3'd0,
        Solicita    = 3'd1,
        AguardaByte = 3'd2,
        Armazena    = 3'd3,
        Verifica    = 3'd4,
        Atualiza    = 3'd5,
        Erro        = 3'd6
    } estado_medida_e;

    // Serial receiver FSM.
    typedef enum logic [2:0] {
        RxOcioso = 3'd0,
        RxInicio = 3'd1,
        RxDados  = 3'd2,
        RxParada = 3'd3
    } estado_rx_e;

    localparam int unsigned BYTES_PACOTE = 5;

    localparam logic [1:0] ERRO_NENHUM   = 2'b00;
    localparam logic [1:0] ERRO_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERRO_CHECKSUM = 2'b10;
    localparam logic [1:0] ERRO_FRAMING  = 2'b11;

    // 8-bit wrap-around sum of the four payload bytes.
    function automatic logic [7:0] soma_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] soma;
        soma = b0 + b1;
        soma = soma + b2;
        soma = soma + b3;
        return soma;
    endfunction

endpackage

// File: rtl/receptor_medida_dht11_if.sv
// Request/result bundle between a measurement client and the DHT11 front end.
interface receptor_medida_dht11_if;
    logic        medir;
    logic        medir_out;
    logic        pronto_medida;
    logic        erro_medida;
    logic [1:0]  erro_codigo;
    logic [15:0] umidade_out;
    logic [15:0] temperatura_out;
    logic [2:0]  db_estado;

    // Client side: issues requests, consumes results.
    modport master (
        output medir,
        input  medir_out,
        input  pronto_medida,
        input  erro_medida,
        input  erro_codigo,
        input  umidade_out,
        input  temperatura_out,
        input  db_estado
    );

    // Front end side.
    modport slave (
        input  medir,
        output medir_out,
        output pronto_medida,
        output erro_medida,
        output erro_codigo,
        output umidade_out,
        output temperatura_out,
        output db_estado
    );
endinterface

// File: rtl/rx_serial_8n1.sv
// 8N1 serial receiver, LSB first, with start-bit glitch rejection.
module rx_serial_8n1 #(
    parameter int unsigned CICLOS_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] dado,
    output logic       pronto,
    output logic       erro_stop,
    output logic [2:0] db_estado
);
    import tusca_dht11_pkg::*;

    localparam int unsigned LARGURA = $clog2(CICLOS_BIT);
    localparam logic [LARGURA-1:0] FIM_BIT  = LARGURA'(CICLOS_BIT - 1);
    localparam logic [LARGURA-1:0] MEIO_BIT = LARGURA'(CICLOS_BIT / 2 - 1);

    estado_rx_e         estado_q, estado_d;
    logic [LARGURA-1:0] cont_q, cont_d;
    logic [2:0]         nbit_q, nbit_d;
    logic [7:0]         dado_q, dado_d;
    logic               pronto_q, pronto_d;
    logic               erro_q, erro_d;
    logic               rx_meta_q, rx_sync_q, rx_ant_q;

    // Synchronise the line and keep the previous sample for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_ant_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_sync_q <= rx_meta_q;
            rx_ant_q  <= rx_sync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= RxOcioso;
            cont_q   <= '0;
            nbit_q   <= '0;
            dado_q   <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            nbit_q   <= nbit_d;
            dado_q   <= dado_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end

    // Receiver next state: half-bit start check, then samples at bit centres.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        nbit_d   = nbit_q;
        dado_d   = dado_q;
        pronto_d = 1'b0;
        erro_d   = 1'b0;
        unique case (estado_q)
            RxOcioso: begin
                if (rx_ant_q && !rx_sync_q) begin
                    estado_d = RxInicio;
                    cont_d   = '0;
                end
            end
            RxInicio: begin
                if (cont_q == MEIO_BIT) begin
                    cont_d = '0;
                    nbit_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    estado_d = rx_sync_q ? RxOcioso : RxDados;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            RxDados: begin
                if (cont_q == FIM_BIT) begin
                    cont_d = '0;
                    dado_d = {rx_sync_q, dado_q[7:1]};
                    nbit_d = nbit_q + 1'b1;
                    if (nbit_q == 3'd7) begin
                        estado_d = RxParada;
                    end
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            RxParada: begin
                if (cont_q == FIM_BIT) begin
                    cont_d   = '0;
                    estado_d = RxOcioso;
                    pronto_d = rx_sync_q;
                    erro_d   = !rx_sync_q;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            default: estado_d = RxOcioso;
        endcase
    end

    assign dado      = dado_q;
    assign pronto    = pronto_q;
    assign erro_stop = erro_q;
    assign db_estado = estado_q;

endmodule

// File: rtl/receptor_medida_dht11.sv
// DHT11 measurement front end: request, receive 5-byte packet, check, publish.
module receptor_medida_dht11
    import tusca_dht11_pkg::*;
#(
    parameter int unsigned CICLOS_BIT     = 5208,
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_serial,
    receptor_medida_dht11_if.slave  medida
);

    localparam int unsigned LARGURA_TO = $clog2(TIMEOUT_CICLOS);
    localparam logic [LARGURA_TO-1:0] TO_MAX = LARGURA_TO'(TIMEOUT_CICLOS - 1);
    localparam logic [2:0] ULTIMO_INDICE = 3'(BYTES_PACOTE - 1);

    logic [7:0] rx_dado;
    logic       rx_pronto;
    logic       rx_erro;
    logic [2:0] rx_db_estado_unused;

    rx_serial_8n1 #(
        .CICLOS_BIT(CICLOS_BIT)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx_serial),
        .dado      (rx_dado),
        .pronto    (rx_pronto),
        .erro_stop (rx_erro),
        .db_estado (rx_db_estado_unused)
    );

    estado_medida_e      estado_q, estado_d;
    logic [1:0]          codigo_q, codigo_d;
    logic [7:0]          buffer_q [BYTES_PACOTE];
    logic [2:0]          indice_q;
    logic [LARGURA_TO-1:0] cont_to_q;
    logic                medir_out_q, pronto_q, erro_q;
    logic [15:0]         umidade_q, temperatura_q;
    logic                timeout;
    logic                checksum_ok;
    logic                grava;
    logic                carrega;

    // Counter saturates so a timeout reached during ARMAZENA still fires afterwards.
    assign timeout     = (cont_to_q == TO_MAX);
    assign checksum_ok = (soma_checksum(buffer_q[0], buffer_q[1], buffer_q[2], buffer_q[3])
                          == buffer_q[4]);

    // FSM state and error-code register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= Ocioso;
            codigo_q <= ERRO_NENHUM;
        end else begin
            estado_q <= estado_d;
            codigo_q <= codigo_d;
        end
    end

    // FSM next state; timeout takes priority over receiver events.
    always_comb begin
        estado_d = estado_q;
        codigo_d = codigo_q;
        grava    = 1'b0;
        carrega  = 1'b0;
        unique case (estado_q)
            Ocioso: begin
                if (medida.medir) begin
                    estado_d = Solicita;
                end
            end
            Solicita: begin
                codigo_d = ERRO_NENHUM;
                estado_d = AguardaByte;
            end
            AguardaByte: begin
                if (timeout) begin
                    estado_d = Erro;
                    codigo_d = ERRO_TIMEOUT;
                end else if (rx_erro) begin
                    estado_d = Erro;
                    codigo_d = ERRO_FRAMING;
                end else if (rx_pronto) begin
                    estado_d = Armazena;
                end
            end
            Armazena: begin
                grava    = 1'b1;
                estado_d = (indice_q == ULTIMO_INDICE) ? Verifica : AguardaByte;
            end
            Verifica: begin
                if (checksum_ok) begin
                    estado_d = Atualiza;
                    carrega  = 1'b1;
                end else begin
                    estado_d = Erro;
                    codigo_d = ERRO_CHECKSUM;
                end
            end
            Atualiza: estado_d = Ocioso;
            Erro:     estado_d = Ocioso;
            default:  estado_d = Ocioso;
        endcase
    end

    // Datapath: buffer, index, timeout counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BYTES_PACOTE; i++) begin
                buffer_q[i] <= '0;
            end
            indice_q      <= '0;
            cont_to_q     <= '0;
            medir_out_q   <= 1'b0;
            pronto_q      <= 1'b0;
            erro_q        <= 1'b0;
            umidade_q     <= '0;
            temperatura_q <= '0;
        end else begin
            if (estado_q == Solicita) begin
                indice_q  <= '0;
                cont_to_q <= '0;
            end else if ((estado_q == AguardaByte || estado_q == Armazena) && !timeout) begin
                cont_to_q <= cont_to_q + 1'b1;
            end
            if (grava) begin
                buffer_q[indice_q] <= rx_dado;
                indice_q           <= indice_q + 1'b1;
            end
            if (carrega) begin
                umidade_q     <= {buffer_q[0], buffer_q[1]};
                temperatura_q <= {buffer_q[2], buffer_q[3]};
            end
            // Pulses are registered from the next state so they line up with it.
            medir_out_q <= (estado_d == Solicita);
            pronto_q    <= (estado_d == Atualiza);
            erro_q      <= (estado_d == Erro);
        end
    end

    assign medida.medir_out       = medir_out_q;
    assign medida.pronto_medida   = pronto_q;
    assign medida.erro_medida     = erro_q;
    assign medida.erro_codigo     = codigo_q;
    assign medida.umidade_out     = umidade_q;
    assign medida.temperatura_out = temperatura_q;
    assign medida.db_estado       = estado_q;

endmodule

// File: tb/tb_receptor_medida_dht11.sv
// Directed bench for the DHT11 measurement front end.
module tb_receptor_medida_dht11;

    localparam int unsigned CB = 16;
    localparam int unsigned TO = 2000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    receptor_medida_dht11_if mif ();

    receptor_medida_dht11 #(
        .CICLOS_BIT     (CB),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_serial (rx),
        .medida    (mif.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_erros  = 0;

    int n_medir_out = 0;
    int n_pronto    = 0;
    int n_erro      = 0;
    int ciclo       = 0;
    int ciclo_entrada = 0;
    int ciclo_erro    = 0;
    logic [15:0] umid_pronto = '0;
    logic [15:0] temp_pronto = '0;
    logic [2:0]  estado_ant  = '0;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        ciclo++;
        if (mif.medir_out) n_medir_out++;
        if (mif.pronto_medida) begin
            n_pronto++;
            umid_pronto = mif.umidade_out;
            temp_pronto = mif.temperatura_out;
        end
        if (mif.erro_medida) begin
            n_erro++;
            ciclo_erro = ciclo;
        end
        if (mif.db_estado == 3'd2 && estado_ant == 3'd1) ciclo_entrada = ciclo;
        estado_ant = mif.db_estado;
    end

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic enviar_bit(input logic b);
        rx = b;
        ciclos(CB);
    endtask

    task automatic enviar_byte(input logic [7:0] d, input logic stop);
        enviar_bit(1'b0);
        for (int i = 0; i < 8; i++) enviar_bit(d[i]);
        enviar_bit(stop);
        rx = 1'b1;
        ciclos(2);
    endtask

    task automatic enviar_pacote(input logic [39:0] p);
        for (int i = 4; i >= 0; i--) enviar_byte(p[i*8 +: 8], 1'b1);
        ciclos(10);
    endtask

    task automatic pulso_medir();
        mif.medir = 1'b1;
        ciclos(1);
        mif.medir = 1'b0;
        ciclos(2);
    endtask

    int b_m, b_p, b_e;

    task automatic marcar();
        b_m = n_medir_out;
        b_p = n_pronto;
        b_e = n_erro;
    endtask

    initial begin
        mif.medir = 1'b0;
        ciclos(3);
        verificar("reset_umidade", mif.umidade_out, 0);
        verificar("reset_temperatura", mif.temperatura_out, 0);
        verificar("reset_codigo", mif.erro_codigo, 0);
        verificar("reset_estado", mif.db_estado, 0);
        verificar("reset_pulsos", {mif.medir_out, mif.pronto_medida, mif.erro_medida}, 0);
        reset = 1'b0;
        ciclos(3);

        // Nominal packet.
        marcar();
        pulso_medir();
        verificar("nominal_medir_out", n_medir_out - b_m, 1);
        enviar_pacote(40'h3C_00_19_05_5A);
        verificar("nominal_pronto", n_pronto - b_p, 1);
        verificar("nominal_erro", n_erro - b_e, 0);
        verificar("nominal_umidade", mif.umidade_out, 16'h3C00);
        verificar("nominal_temperatura", mif.temperatura_out, 16'h1905);
        verificar("nominal_umid_no_pronto", umid_pronto, 16'h3C00);
        verificar("nominal_codigo", mif.erro_codigo, 0);
        verificar("nominal_estado", mif.db_estado, 0);

        // Checksum wrap-around: FF+FF+02+01 = 0x201 -> 0x01.
        marcar();
        pulso_medir();
        enviar_pacote(40'hFF_FF_02_01_01);
        verificar("wrap_pronto", n_pronto - b_p, 1);
        verificar("wrap_umidade", mif.umidade_out, 16'hFFFF);
        verificar("wrap_temperatura", mif.temperatura_out, 16'h0201);
        verificar("wrap_temp_no_pronto", temp_pronto, 16'h0201);

        // Bad checksum keeps previous data.
        marcar();
        pulso_medir();
        enviar_pacote(40'h3C_00_19_05_5B);
        verificar("cks_erro", n_erro - b_e, 1);
        verificar("cks_pronto", n_pronto - b_p, 0);
        verificar("cks_codigo", mif.erro_codigo, 2'b10);
        verificar("cks_umidade", mif.umidade_out, 16'hFFFF);
        verificar("cks_temperatura", mif.temperatura_out, 16'h0201);

        // Timeout after three bytes.
        marcar();
        pulso_medir();
        verificar("to_codigo_limpo", mif.erro_codigo, 0);
        enviar_byte(8'h11, 1'b1);
        enviar_byte(8'h22, 1'b1);
        enviar_byte(8'h33, 1'b1);
        for (int i = 0; i < 3000 && n_erro == b_e; i++) @(negedge clock);
        ciclos(2);
        verificar("to_erro", n_erro - b_e, 1);
        verificar("to_latencia", ciclo_erro - ciclo_entrada, TO);
        verificar("to_codigo", mif.erro_codigo, 2'b01);
        verificar("to_umidade", mif.umidade_out, 16'hFFFF);

        // Framing error on the second byte.
        marcar();
        pulso_medir();
        enviar_byte(8'h3C, 1'b1);
        enviar_byte(8'h00, 1'b0);
        ciclos(10);
        verificar("frm_erro", n_erro - b_e, 1);
        verificar("frm_codigo", mif.erro_codigo, 2'b11);
        verificar("frm_temperatura", mif.temperatura_out, 16'h0201);

        // Stray byte, busy medir and start-bit glitch.
        marcar();
        enviar_byte(8'h55, 1'b1);
        ciclos(5);
        verificar("stray_eventos", (n_pronto - b_p) + (n_erro - b_e) + (n_medir_out - b_m), 0);
        verificar("stray_estado", mif.db_estado, 0);
        pulso_medir();
        enviar_byte(8'h10, 1'b1);
        enviar_byte(8'h20, 1'b1);
        pulso_medir();
        rx = 1'b0;
        ciclos(4);
        rx = 1'b1;
        ciclos(40);
        enviar_byte(8'h30, 1'b1);
        enviar_byte(8'h40, 1'b1);
        enviar_byte(8'hA0, 1'b1);
        ciclos(10);
        verificar("busy_medir_out", n_medir_out - b_m, 1);
        verificar("glitch_pronto", n_pronto - b_p, 1);
        verificar("glitch_erro", n_erro - b_e, 0);
        verificar("glitch_umidade", mif.umidade_out, 16'h1020);
        verificar("glitch_temperatura", mif.temperatura_out, 16'h3040);

        // Reset in the middle of a packet.
        pulso_medir();
        enviar_byte(8'h01, 1'b1);
        enviar_byte(8'h02, 1'b1);
        rx = 1'b0;
        ciclos(30);
        reset = 1'b1;
        ciclos(2);
        rx = 1'b1;
        reset = 1'b0;
        ciclos(5);
        verificar("rst_umidade", mif.umidade_out, 0);
        verificar("rst_temperatura", mif.temperatura_out, 0);
        verificar("rst_codigo", mif.erro_codigo, 0);
        verificar("rst_estado", mif.db_estado, 0);
        marcar();
        pulso_medir();
        enviar_pacote(40'h3C_00_19_05_5A);
        verificar("rst_pos_pronto", n_pronto - b_p, 1);
        verificar("rst_pos_umidade", mif.umidade_out, 16'h3C00);
        verificar("rst_pos_temperatura", mif.temperatura_out, 16'h1905);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule

// File: doc/receptor_medida_dht11.md
# receptor_medida_dht11

Measurement front end of the TUSCA datapath. On a `medir` request it pulses a request line to the external DHT11 bridge. It then receives a 5-byte 8N1 serial packet, validates the checksum, and publishes 16-bit humidity and temperature words. These feed the temperature and humidity comparators. Timeouts, bad checksums and framing errors are reported without disturbing the last good measurement.

## Interface
Parameters:
- `CICLOS_BIT`, default 5208: clock cycles per serial bit (9600 baud at 50 MHz); must be ≥ 4.
- `TIMEOUT_CICLOS`, default 50_000_000: maximum cycles from request to the 5th byte (1 s).

Ports:
- `clock`, in, 1: single system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `medir`, in, 1: measurement request; sampled only in OCIOSO.
- `rx_serial`, in, 1: asynchronous serial line, idle high, 8N1, LSB first.
- `medir_out`, out, 1: one-cycle request pulse to the DHT11 bridge.
- `pronto_medida`, out, 1: one-cycle pulse when new valid data is published.
- `erro_medida`, out, 1: one-cycle pulse on a failed measurement.
- `erro_codigo`, out, 2: 00 none, 01 timeout, 10 checksum, 11 framing.
- `umidade_out`, out, 16: {umid_int, umid_dec}.
- `temperatura_out`, out, 16: {temp_int, temp_dec}.
- `db_estado`, out, 3: current FSM state encoding.

## Operation
- Packet byte order: umid_int, umid_dec, temp_int, temp_dec, checksum.
- Checksum is valid when it equals (sum of bytes 0–3) mod 256, using an 8-bit wrap-around adder.
- FSM states and transitions:
  - OCIOSO=0: `medir`=1 → SOLICITA.
  - SOLICITA=1: `medir_out`=1; byte index and timeout counter cleared → AGUARDA_BYTE.
  - AGUARDA_BYTE=2: receiver byte-ready → ARMAZENA; receiver stop-bit error → ERRO (11); timeout → ERRO (01).
  - ARMAZENA=3: byte written to buffer[index], index++; if index was 4 → VERIFICA, else → AGUARDA_BYTE.
  - VERIFICA=4: checksum match → ATUALIZA, else → ERRO (10).
  - ATUALIZA=5: output registers loaded from buffer, `pronto_medida`=1 → OCIOSO.
  - ERRO=6: `erro_medida`=1, outputs unchanged → OCIOSO.
- `erro_codigo` is written on entry to ERRO. It is held until the next accepted `medir` (cleared in SOLICITA).
- `medir` is ignored in every state other than OCIOSO; no queuing.
- The serial receiver runs continuously. Bytes completing outside AGUARDA_BYTE are discarded.
- Timeout: the counter increments every cycle from AGUARDA_BYTE entry until VERIFICA and fires at TIMEOUT_CICLOS−1. If byte-ready and timeout occur in the same cycle, timeout wins.
- Receiver behaviour:
  - 2-flop synchronizer on `rx_serial`.
  - Start bit detected on a falling edge; the line is re-sampled at CICLOS_BIT/2.
  - If the line is high at that re-sample, the edge is treated as a glitch and the receiver returns to idle.
  - 8 data bits are sampled at bit centres, then the stop bit.
  - Stop bit = 1 gives a byte-ready pulse; stop bit = 0 gives a stop-error pulse. Either pulse is one cycle, in the cycle after the stop sample.
- Reset values, all outputs: `umidade_out`=0, `temperatura_out`=0, `erro_codigo`=00, `db_estado`=0, all pulses 0.
- Reset mid-packet: the receiver returns to idle and the buffer is cleared.

## Timing
- `medir` high at edge k in OCIOSO → `medir_out` high for the whole cycle k+1 (exactly one cycle).
- 5th byte-ready at edge j → ARMAZENA at j+1 → VERIFICA at j+2 → ATUALIZA or ERRO at j+3.
- The data outputs change on the same edge that raises `pronto_medida`.
- The receiver adds 2 synchronizer cycles of latency relative to the line.
- The next `medir` is accepted at the earliest one cycle after `pronto_medida` or `erro_medida`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `tusca_dht11_pkg`:
  - FSM state encodings.
  - `BYTES_PACOTE` = 5.
  - Error code constants ERRO_NENHUM, ERRO_TIMEOUT, ERRO_CHECKSUM, ERRO_FRAMING.
- Sub-module `rx_serial_8n1` (parameter CICLOS_BIT; outputs `dado[7:0]`, `pronto`, `erro_stop`, `db_estado[2:0]`). It is reused by config reception.
- Top level contains: FSM, 5×8 byte buffer, 3-bit index, timeout counter of width $clog2(TIMEOUT_CICLOS), checksum adder.

## Test plan
Simulation parameters: CICLOS_BIT=16, TIMEOUT_CICLOS=2000.
- Nominal packet: `medir` pulse; send 3C 00 19 05 5A → one `medir_out` pulse; `pronto_medida` pulse; `umidade_out`=0x3C00, `temperatura_out`=0x1905; `erro_codigo`=00.
- Checksum wrap-around: send FF FF 02 01 01 → pronto, `umidade_out`=0xFFFF, `temperatura_out`=0x0201.
- Bad checksum: send 3C 00 19 05 5B → `erro_medida` pulse; `erro_codigo`=10; outputs keep previous values.
- Timeout: send only 3 bytes then idle → `erro_medida` exactly 2000 cycles after AGUARDA_BYTE entry; `erro_codigo`=01.
- Framing error: 2nd byte sent with stop bit 0 → `erro_codigo`=11.
- Stray and busy inputs: a byte sent while in OCIOSO is ignored; a second `medir` during reception is ignored; a 4-cycle start-bit glitch produces no byte.
- Reset mid-packet: reset after 2 bytes → all outputs 0, state 0; a following full packet is received correctly.
